// File: rtl/kernel_normalizer.sv
// kernel_normalizer: divides each active kernel coefficient (shifted by FRAC_W) by the kernel sum
// using a serial restoring divider; the published kernel only changes on entry to DONE.
module kernel_normalizer #(
  parameter int MAX_KERNEL = 5,
  parameter int IN_W       = 8,
  parameter int SUM_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int OUT_W      = 8,
  parameter bit ODD_ONLY   = 1'b1,
  localparam int NUM_W     = IN_W + FRAC_W,
  localparam int KS_W      = $clog2(MAX_KERNEL + 1)
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic                                  round_en,
  input  logic [KS_W-1:0]                       kernel_size,
  input  logic [MAX_KERNEL*MAX_KERNEL*IN_W-1:0] nn_kernel,
  input  logic [SUM_W-1:0]                      sum,
  output logic [MAX_KERNEL*MAX_KERNEL*OUT_W-1:0] kernel,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int CELLS = MAX_KERNEL * MAX_KERNEL;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [NUM_W:0] Q_MAX = (NUM_W+1)'((2 ** OUT_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_STORE, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [IN_W-1:0]    r_nn     [CELLS];
  logic [OUT_W-1:0]   r_work   [CELLS];
  logic [OUT_W-1:0]   r_kernel [CELLS];
  logic [SUM_W-1:0]   r_sum;
  logic [KS_W-1:0]    r_n, r_x, r_y;
  logic               r_round, r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_W-1:0]   r_num, r_quo;
  logic [SUM_W:0]     r_rem;

  logic [IDX_W-1:0]   w_idx;
  logic [KS_W-1:0]    w_nm1;
  logic               w_bad, w_last_x, w_last, w_div_end, w_ge, w_rnd_up;
  logic [NUM_W-1:0]   w_num_cur;
  logic [SUM_W:0]     w_rem_cur, w_rem_sh, w_rem_nx;
  logic [NUM_W:0]     w_q_rnd;
  logic [OUT_W-1:0]   w_q_sat;

  always_comb begin
    w_idx     = IDX_W'(r_y) * IDX_W'(MAX_KERNEL) + IDX_W'(r_x);
    w_nm1     = r_n - KS_W'(1);
    w_bad     = (r_sum == '0) || (r_n == '0) || (r_n > KS_W'(MAX_KERNEL)) ||
                (ODD_ONLY && !r_n[0]);
    w_last_x  = (r_x == w_nm1);
    w_last    = w_last_x && (r_y == w_nm1);
    w_div_end = (r_cnt == CNT_W'(NUM_W - 1));
    // The first divide cycle of each element takes its numerator straight from the latched
    // coefficient, so no separate load state is needed between STORE and DIV.
    w_num_cur = (r_cnt == '0) ? {r_nn[w_idx], {FRAC_W{1'b0}}} : r_num;
    w_rem_cur = (r_cnt == '0) ? '0 : r_rem;
    w_rem_sh  = {w_rem_cur[SUM_W-1:0], w_num_cur[NUM_W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_sum});
    w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_sum}) : w_rem_sh;
    w_rnd_up  = r_round && ({r_rem, 1'b0} >= {2'b00, r_sum});
    w_q_rnd   = {1'b0, r_quo} + {{NUM_W{1'b0}}, w_rnd_up};
    w_q_sat   = (w_q_rnd > Q_MAX) ? '1 : w_q_rnd[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = w_bad ? S_DONE : S_DIV;
      S_DIV:   if (w_div_end) w_next = S_STORE;
      S_STORE: w_next = w_last ? S_DONE : S_DIV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CHECK) || (r_state == S_DIV) || (r_state == S_STORE);
    done = (r_state == S_DONE);
    err  = r_err;
    kernel = '0;
    for (int unsigned i = 0; i < CELLS; i++) kernel[i*OUT_W +: OUT_W] = r_kernel[i];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        r_nn[i]     <= '0;
        r_work[i]   <= '0;
        r_kernel[i] <= '0;
      end
      r_sum   <= '0;
      r_n     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_round <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          for (int unsigned i = 0; i < CELLS; i++) r_nn[i] <= nn_kernel[i*IN_W +: IN_W];
          r_sum   <= sum;
          r_n     <= kernel_size;
          r_round <= round_en;
          r_err   <= 1'b0;
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err <= 1'b1;
            for (int unsigned i = 0; i < CELLS; i++) r_kernel[i] <= '0;
          end else begin
            for (int unsigned i = 0; i < CELLS; i++) r_work[i] <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_cnt <= '0;
          end
        end
        S_DIV: begin
          r_num <= w_num_cur << 1;
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[NUM_W-2:0], w_ge};
          r_cnt <= w_div_end ? '0 : (r_cnt + CNT_W'(1));
        end
        S_STORE: begin
          r_work[w_idx] <= w_q_sat;
          // Publishing bypasses the working buffer for the final element written on this same edge.
          if (w_last) begin
            for (int unsigned i = 0; i < CELLS; i++)
              r_kernel[i] <= (IDX_W'(i) == w_idx) ? w_q_sat : r_work[i];
          end
          if (w_last_x) begin
            r_x <= '0;
            r_y <= r_y + KS_W'(1);
          end else begin
            r_x <= r_x + KS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_normalizer.sv
// Self-checking bench for kernel_normalizer: directed scenarios plus randomized runs
// compared against an arithmetic model of the normalisation rules.
module tb_kernel_normalizer;

  localparam int MK     = 5;
  localparam int IN_W   = 8;
  localparam int SUM_W  = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 8;
  localparam int KS_W   = 3;
  localparam int NUM_W  = IN_W + FRAC_W;
  localparam int CELLS  = MK * MK;
  localparam int KW     = CELLS * OUT_W;
  localparam int NW     = CELLS * IN_W;

  logic             clk;
  logic             n_rst;
  logic             start;
  logic             round_en;
  logic [KS_W-1:0]  kernel_size;
  logic [NW-1:0]    nn_kernel;
  logic [SUM_W-1:0] sum;
  logic [KW-1:0]    kernel;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  kernel_normalizer #(
    .MAX_KERNEL(MK), .IN_W(IN_W), .SUM_W(SUM_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .ODD_ONLY(1'b1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .round_en(round_en), .kernel_size(kernel_size),
    .nn_kernel(nn_kernel), .sum(sum), .kernel(kernel), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic bit ref_err(input int n, input int s);
    return (s == 0) || (n == 0) || (n > MK) || (n % 2 == 0);
  endfunction

  // Cycle in which done is high, counted from the start edge T.
  function automatic int spec_lat(input int n, input int s);
    if (ref_err(n, s)) return 2;
    return 2 + n * n * (NUM_W + 1);
  endfunction

  function automatic logic [KW-1:0] ref_kernel(input int n, input logic [NW-1:0] nn,
                                               input int s, input bit rnd);
    logic [KW-1:0] k;
    longint num, q, r;
    k = '0;
    if (ref_err(n, s)) return k;
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < n; x++) begin
        num = longint'(nn[(y*MK+x)*IN_W +: IN_W]) * (longint'(1) << FRAC_W);
        q = num / s;
        r = num % s;
        if (rnd && (2 * r >= s)) q++;
        if (q > (1 << OUT_W) - 1) q = (1 << OUT_W) - 1;
        k[(y*MK+x)*OUT_W +: OUT_W] = OUT_W'(q);
      end
    end
    return k;
  endfunction

  function automatic logic [NW-1:0] rand_nn(input int lo, input int hi);
    logic [NW-1:0] v;
    for (int i = 0; i < CELLS; i++) v[i*IN_W +: IN_W] = IN_W'($urandom_range(hi, lo));
    return v;
  endfunction

  function automatic logic [NW-1:0] fill_nn(input int val);
    logic [NW-1:0] v;
    for (int i = 0; i < CELLS; i++) v[i*IN_W +: IN_W] = IN_W'(val);
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] entry(input logic [KW-1:0] k, input int y, input int x);
    return k[(y*MK+x)*OUT_W +: OUT_W];
  endfunction

  // Drives one start pulse across edge T, then scrambles the inputs to prove they were latched.
  task automatic launch(input int n, input logic [NW-1:0] nn, input int s, input bit rnd);
    @(negedge clk);
    kernel_size = KS_W'(n);
    nn_kernel   = nn;
    sum         = SUM_W'(s);
    round_en    = rnd;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    nn_kernel   = rand_nn(0, 255);
    sum         = SUM_W'($urandom);
    kernel_size = KS_W'($urandom_range(7, 0));
    round_en    = ~rnd;
  endtask

  // edges = number of clock edges after T before done is seen (spec latency minus one).
  task automatic wait_done(output int edges, output bit busy_ok);
    edges   = -1;
    busy_ok = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done) begin
        edges = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; round_en = 1'b0; kernel_size = '0;
    nn_kernel = rand_nn(0, 255); sum = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kernel, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: kernel=%h busy=%b done=%b err=%b, required all zero", kernel, busy, done, err);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int edges;
    bit bok;
    nn  = fill_nn(1);
    exp = ref_kernel(3, nn, 3, 1'b0);
    launch(3, nn, 3, 1'b0);
    wait_done(edges, bok);
    checks++;
    if (edges !== spec_lat(3, 3) - 1) begin
      errors++; $display("FAIL basic_latency: %0d edges after start, required %0d", edges, spec_lat(3, 3) - 1);
    end
    checks++;
    if (!bok) begin errors++; $display("FAIL basic_busy: busy not high exactly T+1..T+154"); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: err=%b, required 0", err); end
    checks++;
    if (kernel !== exp) begin errors++; $display("FAIL basic_kernel: got %h, required %h", kernel, exp); end
    checks++;
    if (entry(kernel, 2, 2) !== 8'd85) begin
      errors++; $display("FAIL basic_entry22: got %0d, required 85", entry(kernel, 2, 2));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b one cycle after DONE, required 0", done); end
  endtask

  task automatic test_round();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    logic [OUT_W-1:0] want;
    int edges;
    bit bok;
    nn = fill_nn(2);
    for (int r = 0; r < 2; r++) begin
      exp  = ref_kernel(3, nn, 3, r[0]);
      want = (r == 1) ? OUT_W'(171) : OUT_W'(170);
      launch(3, nn, 3, r[0]);
      wait_done(edges, bok);
      checks++;
      if (kernel !== exp) begin
        errors++; $display("FAIL round%0d_kernel: got %h, required %h", r, kernel, exp);
      end
      checks++;
      if (entry(kernel, 1, 1) !== want) begin
        errors++; $display("FAIL round%0d_entry: got %0d, required %0d", r, entry(kernel, 1, 1), want);
      end
    end
  endtask

  task automatic test_saturate();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int edges;
    bit bok;
    nn = rand_nn(1, 255);
    nn[IN_W-1:0] = IN_W'(5);
    exp = ref_kernel(1, nn, 4, 1'b0);
    launch(1, nn, 4, 1'b0);
    wait_done(edges, bok);
    checks++;
    if (edges !== spec_lat(1, 4) - 1) begin
      errors++; $display("FAIL sat_latency: %0d edges, required %0d", edges, spec_lat(1, 4) - 1);
    end
    checks++;
    if (entry(kernel, 0, 0) !== 8'd255) begin
      errors++; $display("FAIL sat_entry: got %0d, required 255", entry(kernel, 0, 0));
    end
    checks++;
    if (kernel !== exp) begin errors++; $display("FAIL sat_kernel: got %h, required %h", kernel, exp); end
  endtask

  task automatic test_errors();
    int ns [4] = '{3, 4, 6, 0};
    int ss [4] = '{0, 7, 7, 9};
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int edges;
    bit bok;
    for (int c = 0; c < 4; c++) begin
      nn  = rand_nn(1, 255);
      exp = ref_kernel(1, nn, 1, 1'b0);
      launch(1, nn, 1, 1'b0);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL err_clear%0d: err=%b busy=%b after accepted start, required 0/1", c, err, busy);
      end
      wait_done(edges, bok);
      checks++;
      if (kernel !== exp) begin errors++; $display("FAIL err_pre%0d: got %h, required %h", c, kernel, exp); end
      launch(ns[c], rand_nn(0, 255), ss[c], 1'b0);
      wait_done(edges, bok);
      checks++;
      if (edges !== spec_lat(ns[c], ss[c]) - 1 || err !== 1'b1 || kernel !== '0) begin
        errors++;
        $display("FAIL err_case%0d: edges=%0d err=%b kernel=%h, required edges=%0d err=1 kernel=0",
                 c, edges, err, kernel, spec_lat(ns[c], ss[c]) - 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int s, edges;
    bit rnd;
    nn  = rand_nn(0, 255);
    s   = $urandom_range(2000, 1);
    rnd = 1'($urandom_range(1, 0));
    exp = ref_kernel(3, nn, s, rnd);
    launch(3, nn, s, rnd);
    edges = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done) begin edges = n; break; end
      if (n == 40) begin start = 1'b1; kernel_size = KS_W'(1); sum = SUM_W'(1); end
      @(posedge clk);
      #1 start = 1'b0;
    end
    checks++;
    if (edges !== spec_lat(3, s) - 1 || kernel !== exp) begin
      errors++; $display("FAIL midrun_start: edges=%0d kernel=%h, required edges=%0d kernel=%h",
                         edges, kernel, spec_lat(3, s) - 1, exp);
    end
    start = 1'b1; kernel_size = KS_W'(3); sum = SUM_W'(5);
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int s, edges;
    bit bok;
    launch(5, rand_nn(1, 255), $urandom_range(300, 1), 1'b1);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 49) break;
      @(posedge clk);
    end
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if ({kernel, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_mid: kernel=%h busy=%b done=%b err=%b, required all zero", kernel, busy, done, err);
    end
    @(negedge clk);
    n_rst = 1'b1;
    nn  = rand_nn(0, 255);
    s   = $urandom_range(1000, 1);
    exp = ref_kernel(3, nn, s, 1'b0);
    launch(3, nn, s, 1'b0);
    wait_done(edges, bok);
    checks++;
    if (edges !== spec_lat(3, s) - 1 || kernel !== exp || err !== 1'b0) begin
      errors++; $display("FAIL after_reset_run: edges=%0d err=%b kernel=%h, required edges=%0d err=0 kernel=%h",
                         edges, err, kernel, spec_lat(3, s) - 1, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] nna, nnb;
    logic [KW-1:0] expa, expb, ring;
    int sa, sb, edges;
    bit bok;
    ring = '0;
    for (int y = 0; y < MK; y++)
      for (int x = 0; x < MK; x++)
        if (x >= 3 || y >= 3) ring[(y*MK+x)*OUT_W +: OUT_W] = '1;
    nna  = rand_nn(1, 255);
    sa   = $urandom_range(256, 1);
    expa = ref_kernel(5, nna, sa, 1'b0);
    launch(5, nna, sa, 1'b0);
    wait_done(edges, bok);
    checks++;
    if (edges !== spec_lat(5, sa) - 1 || kernel !== expa) begin
      errors++; $display("FAIL b2b_n5: edges=%0d kernel=%h, required edges=%0d kernel=%h",
                         edges, kernel, spec_lat(5, sa) - 1, expa);
    end
    nnb  = rand_nn(0, 255);
    sb   = $urandom_range(3000, 1);
    expb = ref_kernel(3, nnb, sb, 1'b1);
    launch(3, nnb, sb, 1'b1);
    edges = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done) begin edges = n; break; end
      if (n == 100) begin
        checks++;
        if (kernel !== expa) begin errors++; $display("FAIL b2b_hold: got %h, required %h", kernel, expa); end
      end
      @(posedge clk);
    end
    checks++;
    if (edges !== spec_lat(3, sb) - 1 || kernel !== expb) begin
      errors++; $display("FAIL b2b_n3: edges=%0d kernel=%h, required edges=%0d kernel=%h",
                         edges, kernel, spec_lat(3, sb) - 1, expb);
    end
    checks++;
    if ((kernel & ring) !== '0) begin errors++; $display("FAIL b2b_ring: outer ring %h, required 0", kernel & ring); end
  endtask

  task automatic test_random();
    logic [NW-1:0] nn;
    logic [KW-1:0] exp;
    int n, s, edges;
    bit rnd, bok;
    for (int it = 0; it < 10; it++) begin
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(7, 0)) : int'(2 * $urandom_range(2, 0) + 1);
      case ($urandom_range(3, 0))
        0:       s = $urandom_range(64, 1);
        1:       s = $urandom_range(65535, 1);
        2:       s = $urandom_range(3, 0);
        default: s = $urandom_range(3000, 200);
      endcase
      rnd = 1'($urandom_range(1, 0));
      nn  = rand_nn(0, 255);
      exp = ref_kernel(n, nn, s, rnd);
      launch(n, nn, s, rnd);
      wait_done(edges, bok);
      checks++;
      if (edges !== spec_lat(n, s) - 1 || !bok || err !== ref_err(n, s) || kernel !== exp) begin
        errors++;
        $display("FAIL rand%0d (N=%0d sum=%0d rnd=%0d): edges=%0d busy_ok=%0d err=%b kernel=%h, required edges=%0d err=%0d kernel=%h",
                 it, n, s, rnd, edges, bok, err, kernel, spec_lat(n, s) - 1, ref_err(n, s), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_errors();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
